mcdma_cfg_seq: RTL and testbench

MCDMA_CFG_SEQ -- requirements
Module: mcdma_cfg_seq

---
 rtl/mcdma_cfg_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_mcdma_cfg_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcdma_cfg_seq.sv
// AXI-Lite register sequencer that programs one MCDMA block (MM2S or S2MM) for up to two channels.
// Each command writes CH, CDs, CRs, DMA CR and TDs in that order, with at most one write outstanding.
module mcdma_cfg_seq #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] DMA_BASE   = ADDR_WIDTH'(32'h0000_0000)
) (
    input  logic                  M_AXI_aclk,
    input  logic                  M_AXI_areset,
    input  logic                  start,
    input  logic                  dir,
    input  logic [1:0]            ch_mask,
    input  logic [31:0]           desc0,
    input  logic [31:0]           desc1,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] M_AXI_awaddr,
    output logic [2:0]            M_AXI_awprot,
    output logic                  M_AXI_awvalid,
    input  logic                  M_AXI_awready,
    output logic [31:0]           M_AXI_wdata,
    output logic [3:0]            M_AXI_wstrb,
    output logic                  M_AXI_wvalid,
    input  logic                  M_AXI_wready,
    input  logic [1:0]            M_AXI_bresp,
    input  logic                  M_AXI_bvalid,
    output logic                  M_AXI_bready,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // Fixed 8-slot schedule; slots belonging to a disabled channel are skipped.
    localparam logic [2:0] SLOT_CH    = 3'd0;
    localparam logic [2:0] SLOT_CD0   = 3'd1;
    localparam logic [2:0] SLOT_CD1   = 3'd2;
    localparam logic [2:0] SLOT_CR0   = 3'd3;
    localparam logic [2:0] SLOT_CR1   = 3'd4;
    localparam logic [2:0] SLOT_DMACR = 3'd5;
    localparam logic [2:0] SLOT_TD0   = 3'd6;
    localparam logic [2:0] SLOT_TD1   = 3'd7;

    state_t                r_state;
    logic                  r_dir;
    logic [1:0]            r_mask;
    logic [31:0]           r_desc0;
    logic [31:0]           r_desc1;
    logic [2:0]            r_slot;
    logic                  r_awvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  r_wvalid;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_bready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    function automatic logic slot_en(input logic [2:0] s, input logic [1:0] m);
        logic en;
        case (s)
            SLOT_CH, SLOT_DMACR:         en = 1'b1;
            SLOT_CD0, SLOT_CR0, SLOT_TD0: en = m[0];
            default:                     en = m[1];
        endcase
        return en;
    endfunction

    // Returns {found, slot} for the lowest enabled slot strictly after cur.
    function automatic logic [3:0] next_slot(input logic [2:0] cur, input logic [1:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int s = 7; s >= 1; s--) begin
            if (s > int'(cur) && slot_en(3'(s), m)) begin
                r = {1'b1, 3'(s)};
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] slot_off(input logic [2:0] s);
        logic [11:0] off;
        case (s)
            SLOT_CH:    off = 12'h008;
            SLOT_CD0:   off = 12'h048;
            SLOT_CD1:   off = 12'h088;
            SLOT_CR0:   off = 12'h040;
            SLOT_CR1:   off = 12'h080;
            SLOT_DMACR: off = 12'h000;
            SLOT_TD0:   off = 12'h050;
            default:    off = 12'h090;
        endcase
        return off;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic d, input logic [2:0] s);
        logic [11:0] off;
        off = (d ? 12'h500 : 12'h000) + slot_off(s);
        return DMA_BASE + ADDR_WIDTH'(off);
    endfunction

    function automatic logic [31:0] slot_data(input logic [2:0] s, input logic [1:0] m,
                                              input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] v;
        case (s)
            SLOT_CH:            v = {30'b0, m};
            SLOT_CD0, SLOT_TD0: v = d0;
            SLOT_CD1, SLOT_TD1: v = d1;
            default:            v = 32'd1;
        endcase
        return v;
    endfunction

    // Handshakes: a valid and its payload stay constant until the matching ready is seen high
    // at a rising edge; that edge completes the transfer and the valid drops right after it.
    logic       w_aw_fire;
    logic       w_w_fire;
    logic       w_aw_left;
    logic       w_w_left;
    logic       w_issue_done;
    logic       w_b_fire;
    logic [3:0] w_next;
    logic       w_more;

    assign w_aw_fire    = r_awvalid & M_AXI_awready;
    assign w_w_fire     = r_wvalid & M_AXI_wready;
    assign w_aw_left    = r_awvalid & ~M_AXI_awready;
    assign w_w_left     = r_wvalid & ~M_AXI_wready;
    assign w_issue_done = ~w_aw_left & ~w_w_left;
    assign w_b_fire     = r_bready & M_AXI_bvalid;
    assign w_next       = next_slot(r_slot, r_mask);
    assign w_more       = w_next[3];

    always_ff @(posedge M_AXI_aclk or posedge M_AXI_areset) begin
        if (M_AXI_areset) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_mask    <= 2'b00;
            r_desc0   <= 32'd0;
            r_desc1   <= 32'd0;
            r_slot    <= 3'd0;
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_wvalid  <= 1'b0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'h0;
            r_bready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dir   <= dir;
                        r_mask  <= ch_mask;
                        r_desc0 <= desc0;
                        r_desc1 <= desc1;
                        r_busy  <= 1'b1;
                        if (ch_mask == 2'b00) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_slot    <= SLOT_CH;
                            r_awvalid <= 1'b1;
                            r_awaddr  <= slot_addr(dir, SLOT_CH);
                            r_wvalid  <= 1'b1;
                            r_wdata   <= slot_data(SLOT_CH, ch_mask, desc0, desc1);
                            r_wstrb   <= 4'hF;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                        r_awaddr  <= '0;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                        r_wdata  <= 32'd0;
                        r_wstrb  <= 4'h0;
                    end
                    if (w_issue_done) begin
                        r_state  <= S_RESP;
                        r_bready <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_b_fire) begin
                        r_bready <= 1'b0;
                        if (M_AXI_bresp != 2'b00) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (!w_more) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_slot    <= w_next[2:0];
                            r_awvalid <= 1'b1;
                            r_awaddr  <= slot_addr(r_dir, w_next[2:0]);
                            r_wvalid  <= 1'b1;
                            r_wdata   <= slot_data(w_next[2:0], r_mask, r_desc0, r_desc1);
                            r_wstrb   <= 4'hF;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign M_AXI_awaddr  = r_awaddr;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_awvalid = r_awvalid;
    assign M_AXI_wdata   = r_wdata;
    assign M_AXI_wstrb   = r_wstrb;
    assign M_AXI_wvalid  = r_wvalid;
    assign M_AXI_bready  = r_bready;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mcdma_cfg_seq.sv
// Bench for mcdma_cfg_seq: an AXI-Lite slave with programmable ready/response delays logs every
// write, and each command is compared against a register-sequence model built from the rules.
module tb_mcdma_cfg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [1:0]  ch_mask;
    logic [31:0] desc0;
    logic [31:0] desc1;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] M_AXI_awaddr;
    logic [2:0]  M_AXI_awprot;
    logic        M_AXI_awvalid;
    logic        M_AXI_awready = 1'b0;
    logic [31:0] M_AXI_wdata;
    logic [3:0]  M_AXI_wstrb;
    logic        M_AXI_wvalid;
    logic        M_AXI_wready = 1'b0;
    logic [1:0]  M_AXI_bresp = 2'b00;
    logic        M_AXI_bvalid = 1'b0;
    logic        M_AXI_bready;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    mcdma_cfg_seq #(.ADDR_WIDTH(32), .DMA_BASE(32'h0000_0000)) dut (
        .M_AXI_aclk(clk), .M_AXI_areset(rst), .start(start), .dir(dir), .ch_mask(ch_mask),
        .desc0(desc0), .desc1(desc1), .busy(busy), .done(done), .err(err),
        .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot), .M_AXI_awvalid(M_AXI_awvalid),
        .M_AXI_awready(M_AXI_awready), .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
        .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready), .M_AXI_bresp(M_AXI_bresp),
        .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready), .o_dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {addr, data} pairs and the writes actually seen.
    logic [63:0] exp_q[$];
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];

    int   aw_delay = 0, w_delay = 0, b_delay = 0, err_at = -1;
    int   aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_n = 0;
    bit   b_fire = 0, aw_hold = 0, w_hold = 0, prev_done = 0;
    logic [31:0] prev_awaddr = 0, prev_wdata = 0;
    int   done_n = 0, viol = 0;
    logic last_err = 0;
    bit   cmd_timeout;
    logic busy_after;

    // Slave and protocol monitor; all decisions are taken on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_bvalid = 0; M_AXI_bresp = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_fire = 0; aw_hold = 0; w_hold = 0; prev_done = 0;
        end else begin
            if (done) begin
                done_n++;
                last_err = err;
                if (prev_done) viol++;
            end
            if (prev_done && busy) viol++;
            prev_done = done;
            if (!M_AXI_awvalid && M_AXI_awaddr != 0) viol++;
            if (!M_AXI_wvalid && M_AXI_wdata != 0) viol++;
            if (M_AXI_awvalid && M_AXI_awprot != 0) viol++;
            if (M_AXI_wvalid && M_AXI_wstrb != 4'hF) viol++;
            if (M_AXI_bready && (M_AXI_awvalid || M_AXI_wvalid)) viol++;
            if (M_AXI_awvalid && aw_hold && M_AXI_awaddr != prev_awaddr) viol++;
            if (M_AXI_wvalid && w_hold && M_AXI_wdata != prev_wdata) viol++;
            if (M_AXI_awvalid && aw_log.size() > b_n) viol++;
            if (M_AXI_wvalid && w_log.size() > b_n) viol++;

            if (b_fire) begin
                M_AXI_bvalid = 0; M_AXI_bresp = 0; b_fire = 0;
            end else if (M_AXI_bvalid) begin
                if (M_AXI_bready) begin b_fire = 1; b_n++; end
            end else if (aw_log.size() > b_n && w_log.size() > b_n) begin
                if (b_cnt >= b_delay) begin
                    M_AXI_bvalid = 1;
                    M_AXI_bresp = (b_n == err_at) ? 2'b10 : 2'b00;
                    b_cnt = 0;
                    if (M_AXI_bready) begin b_fire = 1; b_n++; end
                end else b_cnt++;
            end

            if (M_AXI_awvalid) begin
                if (aw_cnt >= aw_delay) begin
                    M_AXI_awready = 1; aw_log.push_back(M_AXI_awaddr); aw_cnt = 0; aw_hold = 0;
                end else begin
                    M_AXI_awready = 0; aw_cnt++; aw_hold = 1; prev_awaddr = M_AXI_awaddr;
                end
            end else begin
                M_AXI_awready = 0; aw_cnt = 0; aw_hold = 0;
            end

            if (M_AXI_wvalid) begin
                if (w_cnt >= w_delay) begin
                    M_AXI_wready = 1; w_log.push_back(M_AXI_wdata); w_cnt = 0; w_hold = 0;
                end else begin
                    M_AXI_wready = 0; w_cnt++; w_hold = 1; prev_wdata = M_AXI_wdata;
                end
            end else begin
                M_AXI_wready = 0; w_cnt = 0; w_hold = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: the register program for one command, cut short after a failing write.
    task automatic build_exp(input logic d, input logic [1:0] m, input logic [31:0] d0,
                             input logic [31:0] d1, input int fail_at);
        logic [31:0] base;
        logic [31:0] dsc[2];
        base = d ? 32'h500 : 32'h000;
        dsc[0] = d0; dsc[1] = d1;
        exp_q.delete();
        exp_q.push_back({base + 32'h08, 30'b0, m});
        for (int c = 0; c < 2; c++) if (m[c]) exp_q.push_back({base + 32'h48 + 32'h40 * c, dsc[c]});
        for (int c = 0; c < 2; c++) if (m[c]) exp_q.push_back({base + 32'h40 + 32'h40 * c, 32'd1});
        exp_q.push_back({base, 32'd1});
        for (int c = 0; c < 2; c++) if (m[c]) exp_q.push_back({base + 32'h50 + 32'h40 * c, dsc[c]});
        if (fail_at >= 0) while (exp_q.size() > fail_at + 1) void'(exp_q.pop_back());
    endtask

    function automatic int write_diffs();
        int n = 0;
        if (aw_log.size() != exp_q.size() || w_log.size() != exp_q.size()) n++;
        for (int i = 0; i < exp_q.size(); i++)
            if (i < aw_log.size() && i < w_log.size())
                if ({aw_log[i], w_log[i]} !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic clear_logs();
        aw_log.delete(); w_log.delete(); b_n = 0; done_n = 0; viol = 0;
    endtask

    // One command; inputs are scrambled right after acceptance so latching is exercised.
    task automatic run_cmd(input logic d, input logic [1:0] m, input logic [31:0] d0, input logic [31:0] d1);
        clear_logs();
        dir = d; ch_mask = m; desc0 = d0; desc1 = d1; start = 1;
        tick();
        start = 0; dir = ~d; ch_mask = ~m; desc0 = $urandom; desc1 = $urandom;
        for (int i = 0; i < 400; i++) begin
            if (done_n != 0) break;
            tick();
        end
        cmd_timeout = (done_n == 0);
        tick();
        busy_after = busy;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1; start = 0; dir = 0; ch_mask = 0; desc0 = 0; desc1 = 0;
        tick(); tick();
        checks++;
        if ({busy, done, err, M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                {busy, done, err, M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready});
        end
        checks++;
        if ({M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb, M_AXI_awprot} !== 71'b0) begin
            errors++; $display("FAIL reset_data: awaddr=%h wdata=%h wstrb=%h awprot=%h expected all 0",
                M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb, M_AXI_awprot);
        end
        clear_logs();
        rst = 0; dir = 0; ch_mask = 2'b01; desc0 = 32'h0000_2000; start = 1;
        tick();
        start = 0;
        checks++;
        if ({busy, M_AXI_awvalid, M_AXI_wvalid} !== 3'b111) begin
            errors++; $display("FAIL first_start: busy/awvalid/wvalid=%b expected 111",
                {busy, M_AXI_awvalid, M_AXI_wvalid});
        end
        for (int i = 0; i < 200 && done_n == 0; i++) tick();
        build_exp(0, 2'b01, 32'h0000_2000, 32'h0, -1);
        checks++;
        if (write_diffs() !== 0) begin
            errors++; $display("FAIL first_start_writes: got %0d writes with diffs, expected %0d", aw_log.size(), exp_q.size());
        end
        tick(); tick();
    endtask

    task automatic test_spec_vectors();
        aw_delay = 0; w_delay = 0; b_delay = 0; err_at = -1;
        run_cmd(1, 2'b11, 32'h0000_0100, 32'h0000_0140);
        build_exp(1, 2'b11, 32'h0000_0100, 32'h0000_0140, -1);
        checks++;
        if (cmd_timeout || write_diffs() !== 0 || aw_log.size() !== 8) begin
            errors++; $display("FAIL s2mm_both: got %0d writes timeout=%0d, expected 8 matching", aw_log.size(), cmd_timeout);
        end
        checks++;
        if (aw_log.size() == 8 && {aw_log[5], w_log[5]} !== {32'h500, 32'h1}) begin
            errors++; $display("FAIL s2mm_dmacr: got %h=%h expected 500=1", aw_log[5], w_log[5]);
        end
        checks++;
        if (done_n !== 1 || last_err !== 1'b0) begin
            errors++; $display("FAIL s2mm_done: done pulses=%0d err=%0d expected 1 and 0", done_n, last_err);
        end
        run_cmd(0, 2'b10, 32'h0, 32'h0000_01C0);
        build_exp(0, 2'b10, 32'h0, 32'h0000_01C0, -1);
        checks++;
        if (cmd_timeout || write_diffs() !== 0 || aw_log.size() !== 5) begin
            errors++; $display("FAIL mm2s_ch1: got %0d writes timeout=%0d, expected 5 matching", aw_log.size(), cmd_timeout);
        end
        checks++;
        if (viol !== 0 || busy_after !== 1'b0) begin
            errors++; $display("FAIL mm2s_proto: violations=%0d busy_after=%0d expected 0 and 0", viol, busy_after);
        end
    endtask

    task automatic test_handshake_skew();
        int delays[4][2] = '{'{3, 0}, '{0, 0}, '{0, 3}, '{2, 1}};
        for (int k = 0; k < 4; k++) begin
            logic       d;
            logic [1:0] m;
            logic [31:0] d0, d1;
            aw_delay = delays[k][0]; w_delay = delays[k][1]; b_delay = k;
            d = 1'($urandom_range(0, 1)); m = 2'($urandom_range(1, 3));
            d0 = $urandom & 32'hFFFF_FFC0; d1 = $urandom & 32'hFFFF_FFC0;
            run_cmd(d, m, d0, d1);
            build_exp(d, m, d0, d1, -1);
            checks++;
            if (cmd_timeout || write_diffs() !== 0) begin
                errors++; $display("FAIL skew_%0d: got %0d aw %0d w, expected %0d", k, aw_log.size(), w_log.size(), exp_q.size());
            end
            checks++;
            if (done_n !== 1 || last_err !== 1'b0 || viol !== 0) begin
                errors++; $display("FAIL skew_done_%0d: done=%0d err=%0d viol=%0d expected 1 0 0", k, done_n, last_err, viol);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            logic       d;
            logic [1:0] m;
            logic [31:0] d0, d1;
            int         n;
            d = 1'($urandom_range(0, 1)); m = 2'($urandom_range(1, 3));
            d0 = $urandom; d1 = $urandom;
            n = (m == 2'b11) ? 8 : 5;
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_cmd(d, m, d0, d1);
            build_exp(d, m, d0, d1, err_at);
            checks++;
            if (cmd_timeout || write_diffs() !== 0) begin
                errors++; $display("FAIL rand_%0d: got %0d writes, expected %0d (err_at=%0d)", k, aw_log.size(), exp_q.size(), err_at);
            end
            checks++;
            if (done_n !== 1 || last_err !== (err_at >= 0) || viol !== 0 || busy_after !== 1'b0) begin
                errors++; $display("FAIL rand_done_%0d: done=%0d err=%0d viol=%0d busy=%0d expected 1 %0d 0 0",
                    k, done_n, last_err, viol, busy_after, err_at >= 0);
            end
        end
        err_at = -1;
    endtask

    task automatic test_bresp_err();
        aw_delay = 1; w_delay = 0; b_delay = 1; err_at = 2;
        run_cmd(0, 2'b11, 32'h0000_3000, 32'h0000_3040);
        build_exp(0, 2'b11, 32'h0000_3000, 32'h0000_3040, 2);
        checks++;
        if (aw_log.size() !== 3 || w_log.size() !== 3 || write_diffs() !== 0) begin
            errors++; $display("FAIL bresp_writes: got %0d aw %0d w, expected 3", aw_log.size(), w_log.size());
        end
        checks++;
        if (done_n !== 1 || last_err !== 1'b1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL bresp_done: done=%0d err=%0d busy_after=%0d expected 1 1 0", done_n, last_err, busy_after);
        end
        err_at = -1;
    endtask

    task automatic test_mask_zero();
        logic [1:0] st_fin;
        clear_logs();
        dir = 1; ch_mask = 2'b00; start = 1;
        tick();
        start = 0;
        st_fin = dbg_state;
        checks++;
        if ({done, err, busy, M_AXI_awvalid} !== 4'b1110) begin
            errors++; $display("FAIL mask0_done: done/err/busy/awvalid=%b expected 1110", {done, err, busy, M_AXI_awvalid});
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00 || dbg_state === st_fin) begin
            errors++; $display("FAIL mask0_after: done/busy=%b state=%0d fin_state=%0d expected 00 and a change",
                {done, busy}, dbg_state, st_fin);
        end
        tick(); tick();
        checks++;
        if (aw_log.size() !== 0 || w_log.size() !== 0 || done_n !== 1) begin
            errors++; $display("FAIL mask0_nowrite: writes=%0d done=%0d expected 0 and 1", aw_log.size(), done_n);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        clear_logs();
        aw_delay = 0; w_delay = 0; b_delay = 4;
        dir = 1; ch_mask = 2'b11; desc0 = 32'h100; desc1 = 32'h140; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 100; i++) begin
            if (M_AXI_bready) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reset_mid_resp: bready seen=%0d expected 1", seen);
        end
        rst = 1;
        #1;
        checks++;
        if ({busy, done, err, M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_awaddr, M_AXI_wdata, M_AXI_wstrb, M_AXI_awprot} !== 77'b0) begin
            errors++; $display("FAIL reset_mid_outputs: busy=%0d done=%0d bready=%0d awaddr=%h wdata=%h expected all 0",
                busy, done, M_AXI_bready, M_AXI_awaddr, M_AXI_wdata);
        end
        clear_logs();
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (done_n !== 0 || busy !== 1'b0 || aw_log.size() !== 0) begin
            errors++; $display("FAIL reset_mid_quiet: done=%0d busy=%0d writes=%0d expected 0 0 0", done_n, busy, aw_log.size());
        end
        b_delay = 0;
    endtask

    task automatic test_start_held();
        int first_n = -1;
        bit restarted = 0;
        clear_logs();
        aw_delay = 1; w_delay = 2; b_delay = 0;
        dir = 1; ch_mask = 2'b01; desc0 = 32'h0000_0A00; desc1 = 32'h0000_0B00; start = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_n != 0) break;
        end
        first_n = aw_log.size();
        checks++;
        if (first_n !== 5 || done_n !== 1) begin
            errors++; $display("FAIL held_first: writes=%0d done=%0d expected 5 and 1", first_n, done_n);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (M_AXI_awvalid) begin restarted = 1; break; end
        end
        start = 0;
        checks++;
        if (!restarted) begin
            errors++; $display("FAIL held_restart: second command started=%0d expected 1", restarted);
        end
        for (int i = 0; i < 300 && done_n < 2; i++) tick();
        tick(); tick(); tick();
        build_exp(1, 2'b01, 32'h0000_0A00, 32'h0000_0B00, -1);
        for (int i = 0; i < 5; i++) exp_q.push_back(exp_q[i]);
        checks++;
        if (write_diffs() !== 0 || done_n !== 2 || viol !== 0) begin
            errors++; $display("FAIL held_total: writes=%0d done=%0d viol=%0d expected 10 2 0", aw_log.size(), done_n, viol);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spec_vectors();
        test_handshake_skew();
        test_random();
        test_bresp_err();
        test_mask_zero();
        test_reset_mid();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
